simd_alu_pipe: RTL and testbench
================================

// Module: simd_alu_pipe
// PURPOSE
//  Parametrised multi-lane SIMD ALU; successor to the single-lane 32-bit add/sub/mul stage.
//  Takes LANES packed operand pairs per beat and returns per-lane ADD/SUB/MUL results
//  or a DOTP reduction accumulated across beats. Fixed latency, valid/ready on both sides.
//  Sits between the operand fetch stage and the result writeback buffer.
// PARAMETERS
//  LANES         4   number of parallel lanes (>=1, power of two)
//  DATA_W        32  lane width in bits (2..32)
//  OPCODE_WIDTH  3   opcode width; must hold every opcode_e value
// PORTS
//  clk         in   1               rising-edge clock
//  rstn        in   1               asynchronous active-low reset
//  in_valid    in   1               input beat valid
//  in_ready    out  1               block can accept a beat this cycle
//  in_opcode   in   OPCODE_WIDTH    opcode_e of the beat
//  in_a        in   LANES*DATA_W    operand A, lane i at [i*DATA_W +: DATA_W]
//  in_b        in   LANES*DATA_W    operand B, same packing
//  in_last     in   1               final beat of a DOTP sequence
//  out_valid   out  1               result beat valid
//  out_ready   in   1               downstream accepts result
//  out_opcode  out  OPCODE_WIDTH    opcode of the beat (forwarded)
//  out_data    out  LANES*DATA_W    result, same packing
//  out_last    out  1               in_last forwarded with the beat
// BEHAVIOUR
//  - Reset: all pipeline valids 0, out_valid 0, out_data 0, out_opcode NOOP, out_last 0, acc 0.
//  - Pipeline: 3 stages (S1 operand reg, S2 lane compute, S3 reduce/accumulate/output reg).
//    Latency ALU_LATENCY=3 cycles from accepted beat to out_valid, for every opcode.
//  - Flow: en = !out_valid || out_ready; in_ready = en; all stages and acc advance only on en.
//    Beat accepted when in_valid && in_ready. Bubbles are not compressed. out_* held stable while stalled.
//  - ADD/SUB: per-lane a+b / a-b, signed two's complement, result mod 2^DATA_W.
//  - MUL: per-lane signed a*b, low DATA_W bits of product.
//  - DOTP: s = sum over lanes of signed a*b (each product truncated to DATA_W, sum mod 2^DATA_W);
//    acc_next = acc + s. Lane 0 of out_data = acc_next, other lanes 0. Every DOTP beat emits.
//    If in_last: out_last=1 and acc cleared to 0 after that beat; else acc <= acc_next.
//  - NOOP, STORE_TEMP_S1, STORE_TEMP_S2, STORE_RESULT: out_data 0, beat still emitted, acc untouched.
//  - Non-DOTP beats interleaved between DOTP beats never modify acc; in_last on them only forwarded.
//  - Out-of-range opcode values behave as NOOP.
//  - rstn asserted mid-sequence: pipeline flushed, in-flight beats lost, acc cleared immediately.
// CONFIGURATION
//  SIMD_ALU_SATURATE_EN defined: ADD/SUB clamp per lane to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Not defined: ADD/SUB wrap mod 2^DATA_W. MUL and DOTP always wrap in both builds.
// STRUCTURE
//  - simd_pkg: typedef enum opcode_e {NOOP, ADD, SUB, MUL, DOTP, STORE_TEMP_S1,
//    STORE_TEMP_S2, STORE_RESULT}; localparam ALU_LATENCY = 3.
//  - Sub-module simd_alu_lane: one lane's S1/S2 registers and add/sub/mul datapath
//    (honours SIMD_ALU_SATURATE_EN); instantiated LANES times via generate.
//  - Top: handshake/enable, S3 reduction tree, accumulator, output registers.
// TESTING
//  1 Reset: hold rstn=0, drive in_valid=1 -> out_valid=0, out_data=0, out_opcode=NOOP.
//  2 ADD LANES=4 DATA_W=32, a={1,2,3,0x7FFFFFFF}, b={10,20,30,1} -> 3 cycles later
//    {11,22,33,0x80000000} (wrap build) / 0x7FFFFFFF in lane 3 (SATURATE_EN build).
//  3 DOTP 2 beats: a={1,2,3,4},b={1,1,1,1},last=0 then a={2,2,2,2},b={3,3,3,3},last=1 ->
//    lane0 10 then 34 with out_last=1; next DOTP a=b={1,1,1,1},last=1 -> lane0 4 (acc cleared).
//  4 Backpressure: stream 5 MUL beats, out_ready=0 for 4 cycles mid-stream -> in_ready=0,
//    out_* stable, all 5 results delivered in order, none lost or duplicated.
//  5 Interleave: DOTP(last=0, s=10), ADD, DOTP(last=1, s=5) -> DOTP results 10, 15; ADD correct.
//  6 Reset mid-DOTP after beat s=10, then DOTP s=5 last=1 -> lane0 5; MUL a=-3,b=7 -> -21.

Source files
------------

// File: rtl/simd_pkg.sv
// simd_pkg: opcode encoding and pipeline latency shared by the SIMD ALU files.
package simd_pkg;

    typedef enum logic [2:0] {
        NOOP          = 3'd0,
        ADD           = 3'd1,
        SUB           = 3'd2,
        MUL           = 3'd3,
        DOTP          = 3'd4,
        STORE_TEMP_S1 = 3'd5,
        STORE_TEMP_S2 = 3'd6,
        STORE_RESULT  = 3'd7
    } opcode_e;

    // Cycles from the beat presented with in_valid&&in_ready to out_valid.
    localparam int unsigned ALU_LATENCY = 3;

    // Map a raw opcode field onto opcode_e; values beyond the enum range act as NOOP.
    function automatic opcode_e decode_op(input logic [31:0] raw);
        if (raw > 32'(STORE_RESULT)) begin
            return NOOP;
        end
        return opcode_e'(raw[2:0]);
    endfunction

endpackage

// File: rtl/simd_alu_lane.sv
// simd_alu_lane: one lane's S1 operand registers and S2 add/sub/mul result register.
// Build option SIMD_ALU_SATURATE_EN: ADD/SUB clamp to the signed DATA_W range
// instead of wrapping. MUL (also used as the DOTP lane product) always wraps.
module simd_alu_lane
    import simd_pkg::*;
#(
    parameter int unsigned DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  opcode_e           s1_op,
    output logic [DATA_W-1:0] res
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] arith_res;

`ifdef SIMD_ALU_SATURATE_EN
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W:0] sum_ext;
`endif

    // S1: capture the lane operands whenever the pipeline advances
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
            a_d = in_a;
            b_d = in_b;
        end
    end

    // Add/subtract of the S1 operands, clamped or wrapped depending on the build
    always_comb begin
`ifdef SIMD_ALU_SATURATE_EN
        // One extra sign bit: overflow shows up as the top two bits disagreeing.
        if (s1_op == SUB) begin
            sum_ext = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
        end else begin
            sum_ext = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};
        end
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
            arith_res = sum_ext[DATA_W] ? MIN_NEG : MAX_POS;
        end else begin
            arith_res = sum_ext[DATA_W-1:0];
        end
`else
        if (s1_op == SUB) begin
            arith_res = a_q - b_q;
        end else begin
            arith_res = a_q + b_q;
        end
`endif
    end

    // S2: select the lane result; low product bits are sign-agnostic so MUL is a plain multiply
    always_comb begin
        res_d = res_q;
        if (en) begin
            case (s1_op)
                ADD, SUB:  res_d = arith_res;
                MUL, DOTP: res_d = a_q * b_q;
                default:   res_d = '0;
            endcase
        end
    end

    // Lane state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: LANES-wide SIMD ALU, 3-stage fixed-latency pipeline with
// valid/ready on both sides. S1/S2 live in simd_alu_lane; this file holds the
// handshake, the DOTP lane-sum, the accumulator and the output registers.
// Build option SIMD_ALU_SATURATE_EN: saturating ADD/SUB (see simd_alu_lane).
module simd_alu_pipe
    import simd_pkg::*;
#(
    parameter int unsigned LANES        = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned OPCODE_WIDTH = 3
)
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_WIDTH-1:0]   out_opcode,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      out_last
);

    localparam int unsigned VEC_W = LANES * DATA_W;

    logic                    en;
    logic                    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic                    s1_last_q, s1_last_d, s2_last_q, s2_last_d;
    opcode_e                 s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [OPCODE_WIDTH-1:0] s1_raw_q, s1_raw_d, s2_raw_q, s2_raw_d;
    logic [VEC_W-1:0]        lane_res;
    logic [DATA_W-1:0]       dot_sum, acc_next, acc_q, acc_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [OPCODE_WIDTH-1:0] out_opcode_q, out_opcode_d;
    logic [VEC_W-1:0]        out_data_q, out_data_d;

    // Whole pipeline advances together; it only freezes when a result is stuck at the output
    always_comb begin
        en = !out_valid_q || out_ready;
    end

    // S1/S2 control: valid, decoded opcode, raw opcode for forwarding, last flag
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_op_d    = s1_op_q;
        s1_raw_d   = s1_raw_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_op_d    = s2_op_q;
        s2_raw_d   = s2_raw_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_last_d  = in_last;
            s1_op_d    = decode_op(32'(in_opcode));
            s1_raw_d   = in_opcode;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_op_d    = s1_op_q;
            s2_raw_d   = s1_raw_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_alu_lane #(.DATA_W(DATA_W)) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .en    (en),
            .in_a  (in_a[i*DATA_W +: DATA_W]),
            .in_b  (in_b[i*DATA_W +: DATA_W]),
            .s1_op (s1_op_q),
            .res   (lane_res[i*DATA_W +: DATA_W])
        );
    end

    // S3 reduction: sum of the truncated lane products, modulo 2^DATA_W
    always_comb begin
        dot_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            dot_sum = dot_sum + lane_res[i*DATA_W +: DATA_W];
        end
        acc_next = acc_q + dot_sum;
    end

    // S3 output registers and accumulator; bubbles leave out_data/acc untouched
    always_comb begin
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        acc_d        = acc_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_opcode_d = s2_raw_q;
                out_last_d   = s2_last_q;
                case (s2_op_q)
                    ADD, SUB, MUL: out_data_d = lane_res;
                    DOTP: begin
                        out_data_d = VEC_W'(acc_next);
                        acc_d      = s2_last_q ? '0 : acc_next;
                    end
                    default:       out_data_d = '0;
                endcase
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_op_q      <= NOOP;
            s1_raw_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_op_q      <= NOOP;
            s2_raw_q     <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= OPCODE_WIDTH'(NOOP);
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_op_q      <= s1_op_d;
            s1_raw_q     <= s1_raw_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            s2_op_q      <= s2_op_d;
            s2_raw_q     <= s2_raw_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            acc_q        <= acc_d;
        end
    end

    assign in_ready   = en;
    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed and randomized checks of simd_alu_pipe against a
// lane-by-lane arithmetic model with a software accumulator.
module tb_simd_alu_pipe;
    import simd_pkg::*;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int OPW    = 3;
    localparam int W      = LANES * DATA_W;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] in_opcode = '0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [OPW-1:0] out_opcode;
    logic [W-1:0]   out_data;
    logic           out_last;

    simd_alu_pipe #(.LANES(LANES), .DATA_W(DATA_W), .OPCODE_WIDTH(OPW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0] op;
        logic [W-1:0]   data;
        logic           last;
        int             cyc;
    } beat_t;

    beat_t             exp_q[$];
    beat_t             obs_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] macc = '0;

    // Reference: signed lane arithmetic in 64-bit integers, keep the low DATA_W bits.
    function automatic beat_t model(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic last);
        beat_t  t;
        longint sa, sb, r, s;
        longint lo = -(longint'(1) << (DATA_W - 1));
        longint hi = (longint'(1) << (DATA_W - 1)) - 1;
        t.op = op; t.last = last; t.data = '0; t.cyc = 0; s = 0;
        for (int i = 0; i < LANES; i++) begin
            sa = longint'($signed(a[i*DATA_W +: DATA_W]));
            sb = longint'($signed(b[i*DATA_W +: DATA_W]));
            r = 0;
            if (op == ADD) r = sa + sb;
            else if (op == SUB) r = sa - sb;
            else if (op == MUL) r = sa * sb;
`ifdef SIMD_ALU_SATURATE_EN
            if (op == ADD || op == SUB) begin
                if (r > hi) r = hi;
                if (r < lo) r = lo;
            end
`endif
            if (op == ADD || op == SUB || op == MUL) t.data[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
            s = s + sa * sb;
        end
        if (op == DOTP) begin
            r = longint'(macc) + s;
            t.data[DATA_W-1:0] = r[DATA_W-1:0];
            macc = last ? '0 : r[DATA_W-1:0];
        end
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_word();
        case ($urandom_range(0, 9))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = rnd_word();
        return v;
    endfunction

    task automatic put(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic last);
        in_valid = v; in_opcode = op; in_a = a; in_b = b; in_last = last;
    endtask

    // One clock: record delivered/accepted beats at negedge, then advance past posedge.
    task automatic step();
        beat_t o;
        @(negedge clk);
        if (out_valid && out_ready) begin
            o.op = out_opcode; o.data = out_data; o.last = out_last; o.cyc = cyc;
            obs_q.push_back(o);
        end
        if (in_valid && in_ready && rstn) begin
            o = model(in_opcode, in_a, in_b, in_last);
            o.cyc = cyc;
            exp_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(output bit ok);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) step();
        repeat (4) step();
        ok = (obs_q.size() == exp_q.size());
    endtask

    task automatic test_reset();
        put(1'b1, ADD, '1, '1, 1'b1);
        #2 rstn = 1'b0;
        repeat (3) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
            n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h, expected 0", out_data); end
            n_cmp++; if (out_opcode !== OPW'(NOOP)) begin n_err++; $display("FAIL reset_opcode: got %0d, expected %0d", out_opcode, NOOP); end
            n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b, expected 0", out_last); end
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        macc = '0;
        exp_q.delete(); obs_q.delete();
        step();
    endtask

    task automatic test_add_directed();
        logic [W-1:0] exp_v;
        bit ok;
`ifdef SIMD_ALU_SATURATE_EN
        exp_v = {32'h7FFF_FFFF, 32'd33, 32'd22, 32'd11};
`else
        exp_v = {32'h8000_0000, 32'd33, 32'd22, 32'd11};
`endif
        exp_q.delete(); obs_q.delete();
        put(1'b1, ADD, {32'h7FFF_FFFF, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd30, 32'd20, 32'd10}, 1'b0);
        step();
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != 1) begin
            n_err++; $display("FAIL add_count: got %0d beats, expected 1", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0].data !== exp_v) begin n_err++; $display("FAIL add_data: got %h, expected %h", obs_q[0].data, exp_v); end
            n_cmp++; if (obs_q[0].cyc - exp_q[0].cyc !== int'(ALU_LATENCY)) begin
                n_err++; $display("FAIL add_latency: got %0d, expected %0d", obs_q[0].cyc - exp_q[0].cyc, ALU_LATENCY); end
        end
    endtask

    task automatic test_dotp_directed();
        bit ok;
        exp_q.delete(); obs_q.delete();
        put(1'b1, DOTP, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b0); step();
        put(1'b1, DOTP, {4{32'd2}}, {4{32'd3}}, 1'b1); step();
        put(1'b1, DOTP, {4{32'd1}}, {4{32'd1}}, 1'b1); step();
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != 3) begin
            n_err++; $display("FAIL dotp_count: got %0d beats, expected 3", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0].data !== W'(10) || obs_q[0].last !== 1'b0) begin
                n_err++; $display("FAIL dotp_beat0: got %h last=%b, expected 10 last=0", obs_q[0].data, obs_q[0].last); end
            n_cmp++; if (obs_q[1].data !== W'(34) || obs_q[1].last !== 1'b1) begin
                n_err++; $display("FAIL dotp_beat1: got %h last=%b, expected 34 last=1", obs_q[1].data, obs_q[1].last); end
            n_cmp++; if (obs_q[2].data !== W'(4)) begin
                n_err++; $display("FAIL dotp_cleared: got %h, expected 4", obs_q[2].data); end
            n_cmp++; if (obs_q[2].cyc - exp_q[2].cyc !== int'(ALU_LATENCY)) begin
                n_err++; $display("FAIL dotp_latency: got %0d, expected %0d", obs_q[2].cyc - exp_q[2].cyc, ALU_LATENCY); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] av[5];
        logic [W-1:0] bv[5];
        logic [W-1:0] held;
        bit ok;
        int k = 0;
        exp_q.delete(); obs_q.delete();
        held = '0;
        for (int i = 0; i < 5; i++) begin av[i] = rnd_vec(); bv[i] = rnd_vec(); end
        for (int t = 0; t < 40 && k < 5; t++) begin
            out_ready = !(t >= 3 && t < 7);
            put(1'b1, MUL, av[k], bv[k], 1'b0);
            #1;
            if (t == 3) held = out_data;
            if (t >= 3 && t < 7) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d: got %b, expected 0", t, in_ready); end
            end
            if (t >= 4 && t < 7) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
                    n_err++; $display("FAIL bp_hold t=%0d: got valid=%b data=%h, expected valid=1 data=%h", t, out_valid, out_data, held); end
            end
            if (in_ready) k++;
            step();
        end
        drain(ok);
        n_cmp++; if (!ok || exp_q.size() != 5) begin
            n_err++; $display("FAIL bp_count: got %0d beats, expected %0d (accepted %0d)", obs_q.size(), 5, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].op !== exp_q[i].op) begin
                n_err++; $display("FAIL bp_beat[%0d]: got op=%0d data=%h, expected op=%0d data=%h", i, obs_q[i].op, obs_q[i].data, exp_q[i].op, exp_q[i].data);
            end
        end
    endtask

    task automatic test_interleave();
        bit ok;
        exp_q.delete(); obs_q.delete();
        put(1'b1, DOTP, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b0); step();
        put(1'b1, ADD, rnd_vec(), rnd_vec(), 1'b1); step();
        put(1'b1, DOTP, {32'd2, 32'd1, 32'd1, 32'd1}, {4{32'd1}}, 1'b1); step();
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != 3) begin
            n_err++; $display("FAIL il_count: got %0d beats, expected 3", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0].data !== W'(10)) begin n_err++; $display("FAIL il_dotp0: got %h, expected 10", obs_q[0].data); end
            n_cmp++; if (obs_q[2].data !== W'(15) || obs_q[2].last !== 1'b1) begin
                n_err++; $display("FAIL il_dotp1: got %h last=%b, expected 15 last=1", obs_q[2].data, obs_q[2].last); end
            n_cmp++; if (obs_q[1].data !== exp_q[1].data || obs_q[1].last !== 1'b1) begin
                n_err++; $display("FAIL il_add: got %h last=%b, expected %h last=1", obs_q[1].data, obs_q[1].last, exp_q[1].data); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        exp_q.delete(); obs_q.delete();
        put(1'b1, DOTP, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b0); step();
        drain(ok);
        n_cmp++; if (!ok || obs_q.size() != 1 || obs_q[0].data !== W'(10)) begin
            n_err++; $display("FAIL rm_first: got %0d beats data=%h, expected 1 beat data=10", obs_q.size(), out_data); end
        put(1'b1, DOTP, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b0); step();
        in_valid = 1'b0; step();
        rstn = 1'b0;
        #1;
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rm_async: got %h, expected 0", out_data); end
        step(); step();
        rstn = 1'b1;
        macc = '0;
        exp_q.delete(); obs_q.delete();
        put(1'b1, DOTP, {32'd2, 32'd1, 32'd1, 32'd1}, {4{32'd1}}, 1'b1); step();
        put(1'b1, MUL, {4{32'hFFFF_FFFD}}, {4{32'd7}}, 1'b0); step();
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != 2) begin
            n_err++; $display("FAIL rm_count: got %0d beats, expected 2", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0].data !== W'(5)) begin n_err++; $display("FAIL rm_dotp: got %h, expected 5", obs_q[0].data); end
            n_cmp++; if (obs_q[1].data !== {4{32'hFFFF_FFEB}}) begin
                n_err++; $display("FAIL rm_mul: got %h, expected %h", obs_q[1].data, {4{32'hFFFF_FFEB}}); end
        end
    endtask

    task automatic test_random();
        bit ok;
        exp_q.delete(); obs_q.delete();
        for (int t = 0; t < 400; t++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            put($urandom_range(0, 3) != 0, OPW'($urandom_range(0, 7)), rnd_vec(), rnd_vec(), $urandom_range(0, 3) == 0);
            step();
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].op !== exp_q[i].op || obs_q[i].last !== exp_q[i].last) begin
                n_err++; $display("FAIL rand_beat[%0d]: got op=%0d last=%b data=%h, expected op=%0d last=%b data=%h",
                                  i, obs_q[i].op, obs_q[i].last, obs_q[i].data, exp_q[i].op, exp_q[i].last, exp_q[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_dotp_directed();
        test_backpressure();
        test_interleave();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
